// File: rtl/mii_hex_pkg.sv
// mii_hex_pkg
// Shared types and constants for the MII hex dumper:
//   - main_state_t : formatting FSM states (S_PREFIX exists only when
//                    MII_HEX_OFFSET_EN is defined)
//   - gate_state_t : per-character UART handshake states
//   - ASCII_*      : fixed characters emitted by the formatter
//   - HS_START_TIMEOUT : cycles to wait for tx_active before assuming
//                        the character went out anyway
//   - hex_ascii()  : nibble to uppercase ASCII hex digit
package mii_hex_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_SEP,
    S_CR,
    S_LF
`ifdef MII_HEX_OFFSET_EN
    , S_PREFIX
`endif
  } main_state_t;

  typedef enum logic [1:0] {
    G_IDLE,
    G_ISSUE,
    G_WAIT_START,
    G_WAIT_END
  } gate_state_t;

  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  localparam int unsigned HS_START_TIMEOUT = 4;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/mii_hex_dumper_uart_char_gate.sv
// uart_char_gate
// Sends one character to uart_tx per request and reports completion.
// Ports:
//   clk, reset_n  : clock, async active-low reset
//   req           : one-cycle request to send ch
//   ch            : character to send, sampled with req
//   done          : one-cycle pulse when the character has completed
//   tx_dv, tx_d   : uart_tx data-valid pulse and held character
//   tx_active     : uart_tx busy flag
//
// state        | meaning
// -------------+----------------------------------------------------------
// G_IDLE       | no character in flight; a req pulses tx_dv at once if the
//              | UART is free, else parks in G_ISSUE
// G_ISSUE      | character latched, waiting for the UART to go idle
// G_WAIT_START | tx_dv sent, waiting for tx_active to rise (bounded)
// G_WAIT_END   | UART busy with our character, waiting for it to finish
module uart_char_gate
  import mii_hex_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [7:0] ch,
  output logic       done,
  output logic       tx_dv,
  output logic [7:0] tx_d,
  input  logic       tx_active
);

  localparam logic [2:0] TMO_LOAD = 3'(HS_START_TIMEOUT - 1);

  gate_state_t state;
  logic [2:0]  tmo_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= G_IDLE;
      tmo_cnt <= '0;
      done    <= 1'b0;
      tx_dv   <= 1'b0;
      tx_d    <= 8'h00;
    end else begin
      tx_dv <= 1'b0;
      done  <= 1'b0;
      case (state)
        G_IDLE: begin
          if (req) begin
            tx_d <= ch;
            // The UART may still be finishing a frame started before a
            // reset; never pulse on top of it.
            if (!tx_active) begin
              tx_dv   <= 1'b1;
              tmo_cnt <= TMO_LOAD;
              state   <= G_WAIT_START;
            end else begin
              state <= G_ISSUE;
            end
          end
        end
        G_ISSUE: begin
          if (!tx_active) begin
            tx_dv   <= 1'b1;
            tmo_cnt <= TMO_LOAD;
            state   <= G_WAIT_START;
          end
        end
        G_WAIT_START: begin
          if (tx_active) begin
            state <= G_WAIT_END;
          end else if (tmo_cnt == 3'd0) begin
            // UART never acknowledged; treat as sent so we cannot stall.
            done  <= 1'b1;
            state <= G_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 3'd1;
          end
        end
        G_WAIT_END: begin
          if (!tx_active) begin
            done  <= 1'b1;
            state <= G_IDLE;
          end
        end
        default: state <= G_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mii_hex_dumper.sv
// mii_hex_dumper
// Formats bytes from the receive FIFO as uppercase ASCII hex for uart_tx:
// two digits per byte, space separated, CR LF after BYTES_PER_LINE bytes
// or after the byte flagged in_last.
// Optional feature macro: MII_HEX_OFFSET_EN -- prefixes each line with a
// 16-bit byte offset "XXXX: "; the offset restarts at 0000 per frame.
// Parameters:
//   BYTES_PER_LINE : bytes per output line, 1..255
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   in_dv, in_d, in_last: input byte stream (valid/ready)
//   in_rdy              : byte can be accepted this cycle
//   tx_dv, tx_d         : character start pulse and character to uart_tx
//   tx_active           : uart_tx busy flag
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a byte; in_rdy high
// S_PREFIX | sending "XXXX: " offset prefix, one char per pfx_idx step
// S_HI     | sending high nibble digit
// S_LO     | sending low nibble digit
// S_SEP    | sending space between bytes
// S_CR     | sending carriage return
// S_LF     | sending line feed, line counter clears on completion
module mii_hex_dumper
  import mii_hex_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_dv,
  input  logic [7:0] in_d,
  input  logic       in_last,
  output logic       in_rdy,
  output logic       tx_dv,
  output logic [7:0] tx_d,
  input  logic       tx_active
);

  localparam logic [7:0] LINE_MAX = 8'(BYTES_PER_LINE - 1);

  main_state_t state;
  logic [3:0]  lo_nib;
  logic        last_q;
  logic [7:0]  line_cnt;
  logic        accept;
  logic        line_end;
  logic        req;
  logic [7:0] ch;
  logic        gate_done;

`ifdef MII_HEX_OFFSET_EN
  logic [3:0]  hi_nib;
  logic [15:0] offset;
  logic [2:0]  pfx_idx;

  function automatic logic [7:0] prefix_char(input logic [2:0] idx,
                                             input logic [15:0] off);
    case (idx)
      3'd0:    return hex_ascii(off[15:12]);
      3'd1:    return hex_ascii(off[11:8]);
      3'd2:    return hex_ascii(off[7:4]);
      3'd3:    return hex_ascii(off[3:0]);
      3'd4:    return ASCII_COLON;
      default: return ASCII_SP;
    endcase
  endfunction
`endif

  // Gated by reset_n so the FIFO sees not-ready while reset is held.
  assign in_rdy   = reset_n && (state == S_IDLE);
  assign accept   = in_dv && in_rdy;
  assign line_end = last_q || (line_cnt == LINE_MAX);

  // The request for the next character is raised in the same cycle the
  // previous one completes (or the byte is accepted), so the gate can
  // pulse tx_dv on the following cycle.
  always_comb begin
    req = 1'b0;
    ch  = 8'h00;
    case (state)
      S_IDLE: begin
        if (accept) begin
          req = 1'b1;
`ifdef MII_HEX_OFFSET_EN
          ch  = (line_cnt == 8'd0) ? prefix_char(3'd0, offset)
                                   : hex_ascii(in_d[7:4]);
`else
          ch  = hex_ascii(in_d[7:4]);
`endif
        end
      end
`ifdef MII_HEX_OFFSET_EN
      S_PREFIX: begin
        if (gate_done) begin
          req = 1'b1;
          ch  = (pfx_idx == 3'd5) ? hex_ascii(hi_nib)
                                  : prefix_char(pfx_idx + 3'd1, offset);
        end
      end
`endif
      S_HI: begin
        if (gate_done) begin
          req = 1'b1;
          ch  = hex_ascii(lo_nib);
        end
      end
      S_LO: begin
        if (gate_done) begin
          req = 1'b1;
          ch  = line_end ? ASCII_CR : ASCII_SP;
        end
      end
      S_CR: begin
        if (gate_done) begin
          req = 1'b1;
          ch  = ASCII_LF;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      lo_nib   <= 4'h0;
      last_q   <= 1'b0;
      line_cnt <= 8'd0;
`ifdef MII_HEX_OFFSET_EN
      hi_nib   <= 4'h0;
      offset   <= 16'd0;
      pfx_idx  <= 3'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lo_nib <= in_d[3:0];
            last_q <= in_last;
`ifdef MII_HEX_OFFSET_EN
            hi_nib <= in_d[7:4];
            if (line_cnt == 8'd0) begin
              pfx_idx <= 3'd0;
              state   <= S_PREFIX;
            end else begin
              state <= S_HI;
            end
`else
            state <= S_HI;
`endif
          end
        end
`ifdef MII_HEX_OFFSET_EN
        S_PREFIX: begin
          if (gate_done) begin
            if (pfx_idx == 3'd5) state   <= S_HI;
            else                 pfx_idx <= pfx_idx + 3'd1;
          end
        end
`endif
        S_HI: begin
          if (gate_done) begin
            state <= S_LO;
`ifdef MII_HEX_OFFSET_EN
            // Counted after the prefix so the line shows its first byte's
            // offset; wraps naturally at 16 bits.
            offset <= offset + 16'd1;
`endif
          end
        end
        S_LO: begin
          if (gate_done) begin
            if (line_end) begin
              state <= S_CR;
            end else begin
              line_cnt <= line_cnt + 8'd1;
              state    <= S_SEP;
            end
          end
        end
        S_SEP: begin
          if (gate_done) state <= S_IDLE;
        end
        S_CR: begin
          if (gate_done) state <= S_LF;
        end
        S_LF: begin
          if (gate_done) begin
            line_cnt <= 8'd0;
            state    <= S_IDLE;
`ifdef MII_HEX_OFFSET_EN
            if (last_q) offset <= 16'd0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_char_gate u_gate (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .ch        (ch),
    .done      (gate_done),
    .tx_dv     (tx_dv),
    .tx_d      (tx_d),
    .tx_active (tx_active)
  );

endmodule

// File: tb/tb_mii_hex_dumper.sv
// Bench for mii_hex_dumper. A behavioural UART model raises tx_active
// after each tx_dv and records every character sent.
module tb_mii_hex_dumper;

`ifdef MII_HEX_OFFSET_EN
  localparam int unsigned BPL    = 2;
  localparam int          LO_IDX = 8;
`else
  localparam int unsigned BPL    = 4;
  localparam int          LO_IDX = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_dv = 1'b0;
  logic [7:0] in_d = 8'h00;
  logic       in_last = 1'b0;
  logic       in_rdy;
  logic       tx_dv;
  logic [7:0] tx_d;
  logic       tx_active = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_q[$];
  int         cap_t[$];
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         hold_cycles = 6;
  int         act_cnt = 0;
  bit         uart_never = 1'b0;
  logic       prev_dv = 1'b0;
  int         viol = 0;

  always #5 clk = ~clk;

  mii_hex_dumper #(.BYTES_PER_LINE(BPL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_dv     (in_dv),
    .in_d      (in_d),
    .in_last   (in_last),
    .in_rdy    (in_rdy),
    .tx_dv     (tx_dv),
    .tx_d      (tx_d),
    .tx_active (tx_active)
  );

  always @(posedge clk) cyc++;

  // UART model and monitor
  always @(negedge clk) begin
    if (tx_dv === 1'b1) begin
      cap_q.push_back(tx_d);
      cap_t.push_back(cyc);
      if (tx_active) viol++;
      if (prev_dv === 1'b1) viol++;
      if (!uart_never) begin
        tx_active = 1'b1;
        act_cnt   = hold_cycles;
      end
    end else if (tx_active) begin
      if (act_cnt <= 1) tx_active = 1'b0;
      else act_cnt--;
    end
    prev_dv = tx_dv;
  end

  task automatic exp_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic exp_crlf();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic clear_all();
    cap_q.delete();
    cap_t.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge just after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic keep);
    int n = 0;
    in_d = d;
    in_last = last;
    in_dv = 1'b1;
    while (in_rdy !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_rdy=%b required 1", in_rdy);
    end
    @(negedge clk);
    if (!keep) begin
      in_dv = 1'b0;
      in_last = 1'b0;
    end
  endtask

  task automatic wait_stream(input int n_chars);
    int t = 0;
    while (!(cap_q.size() >= n_chars && in_rdy === 1'b1 && !tx_active) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 20000) begin
      errors++;
      $display("FAIL stream_timeout: got %0d chars, required %0d", cap_q.size(), n_chars);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy: got %b, required 0", in_rdy); end
    checks++;
    if (tx_dv !== 1'b0) begin errors++; $display("FAIL reset_tx_dv: got %b, required 0", tx_dv); end
    checks++;
    if (tx_d !== 8'h00) begin errors++; $display("FAIL reset_tx_d: got 0x%02h, required 0x00", tx_d); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin errors++; $display("FAIL release_in_rdy: got %b, required 1", in_rdy); end
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [7:0] got;
    clear_all();
`ifdef MII_HEX_OFFSET_EN
    exp_str("0000: ");
`endif
    exp_str("A5"); exp_crlf();
    send_byte(8'hA5, 1'b1, 1'b0);
    checks++;
    if (tx_dv !== 1'b1) begin errors++; $display("FAIL first_tx_latency: tx_dv=%b, required 1", tx_dv); end
    wait_stream(exp_q.size());
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL a5_len: got %0d chars, required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL a5_char[%0d]: got 0x%02h, required 0x%02h", i, got, exp_q[i]); end
    end
    checks++;
    if (in_rdy !== 1'b1) begin errors++; $display("FAIL a5_rdy_after: got %b, required 1", in_rdy); end
  endtask

  task automatic test_line_wrap();
    logic [7:0] got;
    clear_all();
`ifdef MII_HEX_OFFSET_EN
    exp_str("0000: 00 01"); exp_crlf();
    exp_str("0002: 02 03"); exp_crlf();
    exp_str("0004: 04 05"); exp_crlf();
`else
    exp_str("00 01 02 03"); exp_crlf();
    exp_str("04 05"); exp_crlf();
`endif
    // in_dv held high throughout: data offered while busy must not duplicate
    for (int b = 0; b < 6; b++) send_byte(8'(b), (b == 5), (b != 5));
    wait_stream(exp_q.size());
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_len: got %0d chars, required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL wrap_char[%0d]: got 0x%02h, required 0x%02h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_frame_restart();
    logic [7:0] got;
    clear_all();
`ifdef MII_HEX_OFFSET_EN
    exp_str("0000: DE AD"); exp_crlf();
    exp_str("0000: BE EF"); exp_crlf();
    exp_str("0002: 01 23"); exp_crlf();
`else
    exp_str("DE AD"); exp_crlf();
    exp_str("BE EF 01 23"); exp_crlf();
`endif
    send_byte(8'hDE, 1'b0, 1'b0);
    send_byte(8'hAD, 1'b1, 1'b0);
    send_byte(8'hBE, 1'b0, 1'b0);
    send_byte(8'hEF, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h23, 1'b1, 1'b0);
    wait_stream(exp_q.size());
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL restart_len: got %0d chars, required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL restart_char[%0d]: got 0x%02h, required 0x%02h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_long_hold();
    logic [7:0] got;
    clear_all();
    hold_cycles = 100;
    viol = 0;
`ifdef MII_HEX_OFFSET_EN
    exp_str("0000: ");
`endif
    exp_str("C3"); exp_crlf();
    send_byte(8'hC3, 1'b1, 1'b0);
    wait_stream(exp_q.size());
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL hold_tx_dv_count: got %0d, required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL hold_char[%0d]: got 0x%02h, required 0x%02h", i, got, exp_q[i]); end
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL hold_dv_while_active: got %0d events, required 0", viol); end
    hold_cycles = 6;
  endtask

  task automatic test_no_active();
    logic [7:0] got;
    int gap;
    clear_all();
    uart_never = 1'b1;
`ifdef MII_HEX_OFFSET_EN
    exp_str("0000: ");
`endif
    exp_str("5A"); exp_crlf();
    send_byte(8'h5A, 1'b1, 1'b0);
    wait_stream(exp_q.size());
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL tmo_len: got %0d chars, required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL tmo_char[%0d]: got 0x%02h, required 0x%02h", i, got, exp_q[i]); end
    end
    // Each character must wait out the 4-cycle start timeout before the next.
    gap = (cap_t.size() >= 2) ? (cap_t[1] - cap_t[0]) : 0;
    checks++;
    if (gap < 5 || gap > 8) begin errors++; $display("FAIL tmo_char_gap: got %0d cycles, required 5..8", gap); end
    checks++;
    if (in_rdy !== 1'b1) begin errors++; $display("FAIL tmo_rdy_after: got %b, required 1", in_rdy); end
    uart_never = 1'b0;
  endtask

  task automatic test_reset_mid_char();
    logic [7:0] got;
    int t = 0;
    clear_all();
    hold_cycles = 20;
    viol = 0;
    send_byte(8'h3C, 1'b0, 1'b0);
    while (cap_q.size() < LO_IDX && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (cap_q.size() < LO_IDX) begin errors++; $display("FAIL mid_reach_lo: got %0d chars, required %0d", cap_q.size(), LO_IDX); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx_dv !== 1'b0) begin errors++; $display("FAIL mid_reset_tx_dv: got %b, required 0", tx_dv); end
    checks++;
    if (in_rdy !== 1'b0) begin errors++; $display("FAIL mid_reset_in_rdy: got %b, required 0", in_rdy); end
    repeat (2) @(negedge clk);
    checks++;
    if (in_rdy !== 1'b0 || tx_dv !== 1'b0) begin errors++; $display("FAIL mid_reset_hold: in_rdy=%b tx_dv=%b, required 0 0", in_rdy, tx_dv); end
    reset_n = 1'b1;
    @(negedge clk);
    clear_all();
`ifdef MII_HEX_OFFSET_EN
    exp_str("0000: ");
`endif
    exp_str("7E"); exp_crlf();
    send_byte(8'h7E, 1'b1, 1'b0);
    wait_stream(exp_q.size());
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_len: got %0d chars, required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL mid_char[%0d]: got 0x%02h, required 0x%02h", i, got, exp_q[i]); end
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL mid_dv_while_active: got %0d events, required 0", viol); end
    hold_cycles = 6;
  endtask

`ifdef MII_HEX_OFFSET_EN
  task automatic test_offset();
    logic [7:0] got;
    clear_all();
    exp_str("0000: 11 22"); exp_crlf();
    exp_str("0002: 33"); exp_crlf();
    exp_str("0000: 44"); exp_crlf();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    send_byte(8'h44, 1'b1, 1'b0);
    wait_stream(exp_q.size());
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL offset_len: got %0d chars, required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL offset_char[%0d]: got 0x%02h, required 0x%02h", i, got, exp_q[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_line_wrap();
    test_frame_restart();
    test_long_hold();
    test_no_active();
    test_reset_mid_char();
`ifdef MII_HEX_OFFSET_EN
    test_offset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
